// File: rtl/gsu_cache_fill_if.sv
// gsu_cache_fill_if: core fetch, ROM read and cache status signals of the GSU cache fill block.
interface gsu_cache_fill_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [7:0]  pbr;
  logic [11:0] cbr;
  logic        flush;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [31:0] line_valid;
  modport slave (
    input  fetch_req, fetch_addr, pbr, cbr, flush, rom_ack, rom_data,
    output fetch_ack, fetch_data, rom_req, rom_addr, line_valid
  );
  modport master (
    output fetch_req, fetch_addr, pbr, cbr, flush, rom_ack, rom_data,
    input  fetch_ack, fetch_data, rom_req, rom_addr, line_valid
  );
endinterface

// File: rtl/gsu_cache_fill.sv
// gsu_cache_fill: 512-byte GSU instruction cache (32x16-byte lines) with ROM line fill and out-of-window bypass.
// Define GSU_CRITICAL_WORD_FIRST_EN to fetch the requested byte first and finish the line in the background.
module gsu_cache_fill (
  input logic             clkin,
  input logic             rst_n,
  gsu_cache_fill_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, FILL = 3'd2, BYPASS = 3'd3, RESP = 3'd4;
`ifdef GSU_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  logic [7:0]  mem [0:511];
  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, off;
  logic [4:0]  line_q;
  logic [3:0]  cnt_q, idx;
  logic [7:0]  rdata_q, data_q;
  logic [23:0] rom_addr_q;
  logic [31:0] valid_q;
  logic        flushed_q, ack_q, rom_req_q, rom_hit, last;
  assign off     = addr_q - {bus.cbr, 4'h0};
  assign idx     = CWF ? addr_q[3:0] + cnt_q : cnt_q;
  assign rom_hit = bus.rom_ack && rom_req_q;
  assign last    = cnt_q == 4'hf;
  assign bus.fetch_ack  = ack_q;
  assign bus.fetch_data = data_q;
  assign bus.rom_req    = rom_req_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.line_valid = valid_q;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (bus.fetch_req && !ack_q) ? LOOKUP : IDLE;
      LOOKUP:  state_d = |off[15:9] ? BYPASS : valid_q[off[8:4]] ? RESP : FILL;
      FILL:    state_d = !(rom_hit && last) ? FILL : CWF ? IDLE : RESP;
      BYPASS:  state_d = rom_hit ? RESP : BYPASS;
      default: state_d = IDLE;
    endcase
  end
  // Line base is addr_q with the low nibble cleared because the window base is 16-byte aligned.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      data_q     <= '0;
      rom_addr_q <= '0;
      valid_q    <= '0;
      flushed_q  <= 1'b0;
      ack_q      <= 1'b0;
      rom_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= 1'b0;
      flushed_q <= (state_q == LOOKUP) ? bus.flush : flushed_q | bus.flush;
      valid_q   <= bus.flush ? '0 :
                   (state_q == FILL && rom_hit && last && !flushed_q) ? valid_q | (32'd1 << line_q) : valid_q;
      if (state_q == IDLE) addr_q <= bus.fetch_addr;
      if (state_q == LOOKUP) begin
        line_q     <= off[8:4];
        rdata_q    <= mem[off[8:0]];
        cnt_q      <= '0;
        rom_req_q  <= state_d != RESP;
        rom_addr_q <= {bus.pbr, addr_q[15:4], (CWF || |off[15:9]) ? addr_q[3:0] : 4'h0};
      end
      if (state_q == FILL && rom_hit) begin
        cnt_q            <= cnt_q + 4'd1;
        rom_addr_q[3:0]  <= idx + 4'd1;
        if (last) rom_req_q <= 1'b0;
        if (idx == addr_q[3:0]) rdata_q <= bus.rom_data;
        if (CWF && cnt_q == 4'd0) begin
          ack_q  <= 1'b1;
          data_q <= bus.rom_data;
        end
      end
      if (state_q == BYPASS && rom_hit) begin
        rdata_q   <= bus.rom_data;
        rom_req_q <= 1'b0;
      end
      if (state_q == RESP) begin
        ack_q  <= 1'b1;
        data_q <= rdata_q;
      end
    end
  end
  always_ff @(posedge clkin)
    if (state_q == FILL && rom_hit) mem[{line_q, idx}] <= bus.rom_data;
endmodule
